// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// It holds one operation at a time. Single-cycle ops complete on the accept
// edge. MUL runs an iterative shift-add over WIDTH cycles. The result and
// flags stay stable in DONE until the consumer takes them.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;
  } resp_t;

  state_t             state, state_nxt;
  resp_t              rsp_q, alu_rsp, mul_rsp;
  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic               big_shift;
  logic               accept;
  logic               mul_last;

  assign accept   = in_valid && (state == IDLE);
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));

  // Single-cycle datapath: result and flags for every op except MUL
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    shamt     = b[SHAMT_W-1:0];
    // Out-of-range amounts are caught on the full b, not just the low field
    big_shift = (b >= WVAL);
    alu_rsp   = '0;
    case (alu_op)
      OP_ADD: begin
        alu_rsp.res   = sum[WIDTH-1:0];
        alu_rsp.carry = sum[WIDTH];
        alu_rsp.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_rsp.res   = diff;
        alu_rsp.carry = (a < b);
        alu_rsp.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: ;  // handled by the iterative path
      OP_SHL: alu_rsp.res = big_shift ? '0 : (a << shamt);
      OP_SHR: alu_rsp.res = big_shift ? '0 : (a >> shamt);
      OP_SRA: alu_rsp.res = big_shift ? {WIDTH{a[WIDTH-1]}}
                                      : WIDTH'($signed(a) >>> shamt);
      OP_AND: alu_rsp.res = a & b;
      OP_OR:  alu_rsp.res = a | b;
      OP_XOR: alu_rsp.res = a ^ b;
      default: alu_rsp.err = 1'b1;
    endcase
    alu_rsp.zero = (alu_rsp.res == '0);
  end

  // Shift-add step. The last step's sum feeds the result register directly.
  always_comb begin
    acc_nxt       = acc + (mplier[0] ? mcand : '0);
    mul_rsp       = '0;
    mul_rsp.res   = acc_nxt[WIDTH-1:0];
    mul_rsp.zero  = (acc_nxt[WIDTH-1:0] == '0);
    mul_rsp.ovf   = |acc_nxt[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs, decoded from the state register only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (alu_op == OP_MUL) ? MUL : DONE;
      end
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand latch, multiplier iteration, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (alu_op == OP_MUL) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        rsp_q  <= alu_rsp;
      end
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (mul_last) rsp_q <= mul_rsp;
    end
  end

  assign result     = rsp_q.res;
  assign flag_zero  = rsp_q.zero;
  assign flag_carry = rsp_q.carry;
  assign flag_ovf   = rsp_q.ovf;
  assign flag_err   = rsp_q.err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8.
// Expected values are computed by hand. Flags are compared as {zero,carry,ovf,err}.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v32, ir32, ov32, or32, z32, c32, o32, e32;
  logic [31:0] a32, b32, r32;
  logic [3:0]  op32;
  logic        v8, ir8, ov8, or8, z8, c8, o8, e8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32),
    .a(a32), .b(b32), .alu_op(op32), .out_valid(ov32), .out_ready(or32),
    .result(r32), .flag_zero(z32), .flag_carry(c32), .flag_ovf(o32), .flag_err(e32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .alu_op(op8), .out_valid(ov8), .out_ready(or8),
    .result(r8), .flag_zero(z8), .flag_carry(c8), .flag_ovf(o8), .flag_err(e8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ov(input bit w8);
    return w8 ? ov8 : ov32;
  endfunction
  function automatic logic cur_ir(input bit w8);
    return w8 ? ir8 : ir32;
  endfunction
  function automatic logic [31:0] cur_res(input bit w8);
    return w8 ? {24'h0, r8} : r32;
  endfunction
  function automatic logic [3:0] cur_flg(input bit w8);
    return w8 ? {z8, c8, o8, e8} : {z32, c32, o32, e32};
  endfunction

  task automatic drive(input bit w8, input logic vld, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xs, ys;
    xs = x;
    ys = y;
    if (w8) begin v8 = vld; op8 = op; a8 = xs[7:0]; b8 = ys[7:0]; end
    else    begin v32 = vld; op32 = op; a32 = xs; b32 = ys; end
  endtask

  // One operation: accept, measure latency, check result/flags, optionally
  // hold back-pressure with a competing in_valid, then release.
  task automatic run(input string tag, input bit w8, input logic [3:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_r, input logic [3:0] exp_f,
                     input int exp_lat, input int hold);
    int lat;
    bit busy_ok, stable_ok;
    logic [31:0] r0;
    logic [3:0]  f0;
    @(negedge clk);
    chk({tag, "/rdy"}, cur_ir(w8), 1'b1);
    drive(w8, 1'b1, op, x, y);
    @(posedge clk);
    @(negedge clk);
    drive(w8, 1'b0, 4'h0, 32'h0, 32'h0);
    lat = 1;
    busy_ok = 1'b1;
    while (!cur_ov(w8) && lat < 100) begin
      if (cur_ir(w8)) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (cur_ir(w8)) busy_ok = 1'b0;
    chk({tag, "/lat"}, lat, exp_lat);
    chk({tag, "/res"}, cur_res(w8), exp_r);
    chk({tag, "/flg"}, cur_flg(w8), exp_f);
    chk({tag, "/busy"}, busy_ok, 1'b1);
    if (hold > 0) begin
      r0 = cur_res(w8);
      f0 = cur_flg(w8);
      stable_ok = 1'b1;
      drive(w8, 1'b1, 4'b0000, 32'h1, 32'h1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (cur_res(w8) !== r0 || cur_flg(w8) !== f0 || cur_ir(w8) || !cur_ov(w8))
          stable_ok = 1'b0;
      end
      chk({tag, "/hold"}, stable_ok, 1'b1);
    end
    if (w8) or8 = 1'b1; else or32 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    or32 = 1'b0;
    drive(w8, 1'b0, 4'h0, 32'h0, 32'h0);
    chk({tag, "/idle"}, {cur_ir(w8), cur_ov(w8)}, 2'b10);
  endtask

  initial begin
    bit quiet;
    rst_n = 1'b0;
    v32 = 0; op32 = 0; a32 = 0; b32 = 0; or32 = 0;
    v8 = 0;  op8 = 0;  a8 = 0;  b8 = 0;  or8 = 0;
    repeat (2) @(negedge clk);
    chk("rst32", {ir32, ov32, r32, z32, c32, o32, e32}, {2'b10, 32'h0, 4'h0});
    chk("rst8",  {ir8, ov8, r8, z8, c8, o8, e8}, {2'b10, 8'h0, 4'h0});
    rst_n = 1'b1;

    run("add_wrap", 0, 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b1100, 1, 0);
    run("add_ovf",  0, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0010, 1, 0);
    run("sub_neg",  0, 4'b0001, 32'd20, 32'd50, 32'hFFFF_FFE2,       4'b0100, 1, 0);
    run("sub_pos",  0, 4'b0001, 32'd50, 32'd20, 32'd30,              4'b0000, 1, 0);
    run("mul",      0, 4'b0010, 32'd1234, 32'd4321, 32'd5332114,     4'b0000, 33, 0);
    run("mul_ovf",  0, 4'b0010, 32'h1_0000, 32'h1_0000, 32'h0,       4'b1010, 33, 0);
    run("shl",      0, 4'b0011, 32'd255, 32'd4, 32'd4080,            4'b0000, 1, 0);
    run("shr",      0, 4'b0100, 32'd1024, 32'd10, 32'd1,             4'b0000, 1, 0);
    run("sra",      0, 4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0000, 1, 0);
    run("shl_big",  0, 4'b0011, 32'd255, 32'd40, 32'h0,              4'b1000, 1, 0);
    run("sra_big",  0, 4'b0101, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 4'b0000, 1, 0);
    run("and",      0, 4'b0110, 32'hF0F0, 32'hFF00, 32'hF000,        4'b0000, 1, 0);
    run("or",       0, 4'b0111, 32'hF0F0, 32'hFF00, 32'hFFF0,        4'b0000, 1, 0);
    run("xor_bp",   0, 4'b1000, 32'hF0F0, 32'hFF00, 32'h0FF0,        4'b0000, 1, 5);
    run("bad_op",   0, 4'b1111, 32'h1234, 32'h5678, 32'h0,           4'b1001, 1, 0);

    // Reset ten cycles into a MUL: aborts immediately and nothing emerges later
    @(negedge clk);
    drive(0, 1'b1, 4'b0010, 32'd1234, 32'd4321);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", ir32, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ir32, ov32, r32}, {2'b10, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ov32 || !ir32) quiet = 1'b0;
    end
    chk("rst_quiet", quiet, 1'b1);
    run("add_post", 0, 4'b0000, 32'd10, 32'd20, 32'd30, 4'b0000, 1, 0);

    run("mul8",     1, 4'b0010, 32'd15, 32'd17, 32'd255,  4'b0000, 9, 0);
    run("mul8_ovf", 1, 4'b0010, 32'd16, 32'd16, 32'd0,    4'b1010, 9, 0);
    run("shl8",     1, 4'b0011, 32'd3, 32'd2, 32'd12,     4'b0000, 1, 0);
    run("shr8",     1, 4'b0100, 32'h80, 32'd7, 32'd1,     4'b0000, 1, 0);
    run("sra8",     1, 4'b0101, 32'h80, 32'd3, 32'hF0,    4'b0000, 1, 0);
    run("shl8_big", 1, 4'b0011, 32'h01, 32'd8, 32'd0,     4'b1000, 1, 0);
    run("sra8_big", 1, 4'b0101, 32'h90, 32'd200, 32'hFF,  4'b0000, 1, 0);
    run("add8_bp",  1, 4'b0000, 32'hFF, 32'h01, 32'h0,    4'b1100, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU.
- Adds valid/ready handshakes on both sides, an iterative shift-add multiplier, extra ops (SRA, AND, OR, XOR) and status flags (zero, carry, overflow, err).
- Sits between the decode/issue stage and writeback. Holds one operation at a time and keeps its result stable under back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from b.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  a, b and alu_op are valid this cycle.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; the shift amount for shift ops.
- alu_op  input  4  operation code.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flag_zero  output  1  result == 0.
- flag_carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
- flag_ovf  output  1  signed overflow for ADD/SUB; for MUL, any nonzero bit in the upper WIDTH bits of the full product; 0 otherwise.
- flag_err  output  1  alu_op was not a defined code.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0 and all flags=0.
  - Multiplier accumulator and counter cleared.
  - Reset mid-MUL or mid-DONE aborts the operation; nothing is emitted afterwards.
- Opcodes:
  - 0000 ADD, 0001 SUB (a-b), 0010 MUL (low WIDTH bits).
  - 0011 SHL, 0100 SHR (logical), 0101 SRA (arithmetic).
  - 0110 AND, 0111 OR, 1000 XOR.
  - Any other code: result=0, flag_err=1, other flags computed from result (flag_zero=1).
- Shifts:
  - Amount = b if b < WIDTH.
  - If b >= WIDTH (any bit above SHAMT_W set, or value >= WIDTH): SHL/SHR give 0; SRA gives all bits = a[WIDTH-1].
- Arithmetic is modulo 2^WIDTH.
  - Carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - Borrow = (a < b) unsigned.
- Handshake:
  - Transfer happens on a rising edge where valid && ready.
  - in_ready = (state==IDLE); it is a combinational decode of the state register.
- State machine (IDLE, MUL, DONE):
  - IDLE + accept, op != MUL: compute, register result/flags, go to DONE. out_valid=1 one cycle after the accept edge.
  - IDLE + accept, op == MUL: latch a and b, clear the accumulator, cnt=0, go to MUL.
  - MUL, each cycle: if multiplier LSB=1, acc += multiplicand (2*WIDTH-bit acc). Then multiplicand <<=1, multiplier >>=1, cnt++.
  - MUL, after WIDTH iterations: register the low WIDTH bits of acc as result, flags from the upper bits, go to DONE. out_valid asserts WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1; result and flags held stable while out_ready=0.
  - DONE + out_ready: go to IDLE and drop out_valid on that edge. Peak throughput is one op per 2 cycles (non-MUL).
- Inputs are ignored when in_ready=0. in_valid asserted during MUL/DONE is not consumed and must be held by the producer.
- result/flags keep their last value after the out transfer; consumers sample only while out_valid=1.

Test Plan:
- WIDTH=32, ADD a=32'hFFFFFFFF, b=1 -> result 0, flag_zero=1, flag_carry=1, flag_ovf=0, out_valid 1 cycle after accept. Then ADD a=32'h7FFFFFFF, b=1 -> result 32'h80000000, flag_ovf=1, flag_carry=0.
- SUB 20-50 -> result 32'hFFFFFFE2, flag_carry(borrow)=1. SUB 50-20 -> 30, flag_carry=0.
- MUL 1234*4321 -> result 5332114, flag_ovf=0, out_valid exactly 33 cycles after accept, in_ready=0 throughout. MUL 32'h10000*32'h10000 -> result 0, flag_ovf=1.
- Shifts:
  - SHL 255<<4 -> 4080.
  - SHR 1024>>10 -> 1.
  - SRA 32'h80000000 by 4 -> 32'hF8000000.
  - SHL by b=40 -> 0.
  - SRA 32'h80000000 by 40 -> 32'hFFFFFFFF.
- Back-pressure: hold out_ready=0 for 5 cycles after an XOR (a=32'hF0F0, b=32'hFF00 -> 32'h0FF0). result is stable and in_ready=0 throughout. Asserting out_ready returns the block to IDLE next edge. Invalid op 4'b1111 -> result 0, flag_err=1.
- Reset 10 cycles into a MUL -> out_valid=0, in_ready=1 immediately (async). A following ADD 10+20 -> 30 completes normally. Rerun the MUL and shift cases with WIDTH=8 (e.g. MUL 15*17 -> 255, ovf=0).
